// File: rtl/serial_frame_receiver.sv
// Receive end of the serial shift-register link: framed LSB-first serial in,
// parallel word out with a valid/ack hold register. All state moves on the falling clock edge.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronized line
// START | counting to the start-bit midpoint to confirm it is still low
// DATA  | sampling DATA_BITS bits at their midpoints, LSB first
// STOP  | sampling the stop bit, then accepting/dropping/rejecting the word
// BREAK | stop bit was low; waiting for the line to return high
module serial_frame_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_in,
  input  logic                 i_rd_ack,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_overrun,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_overrun;
  logic                 r_frame_err;

  logic w_rxs;
  logic w_tick_half;
  logic w_tick_last;
  logic w_bit_last;
  logic w_stop_sample;
  logic w_stop_good;
  logic w_stop_bad;

  assign w_rxs         = r_sync2;
  assign w_tick_half   = (r_tick == TICK_HALF);
  assign w_tick_last   = (r_tick == TICK_LAST);
  assign w_bit_last    = (r_bit == BIT_LAST);
  assign w_stop_sample = (r_state == S_STOP) && w_tick_last;
  assign w_stop_good   = w_stop_sample && w_rxs;
  assign w_stop_bad    = w_stop_sample && !w_rxs;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_rxs) w_next_state = S_START;
      S_START: if (w_tick_half) w_next_state = w_rxs ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick_last && w_bit_last) w_next_state = S_STOP;
      S_STOP:  if (w_tick_last) w_next_state = w_rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rxs) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
  end

  // Shift right so the first (LSB) bit received ends up in bit 0.
  always_comb begin
    w_shift_next = '0;
    for (int i = 0; i < DATA_BITS - 1; i++) w_shift_next[i] = r_shift[i+1];
    w_shift_next[DATA_BITS-1] = w_rxs;
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_START: begin
          r_bit <= '0;
          if (w_tick_half) r_tick <= '0;
          else             r_tick <= r_tick + TICK_ONE;
        end
        S_DATA: begin
          if (w_tick_last) begin
            r_tick  <= '0;
            r_shift <= w_shift_next;
            if (w_bit_last) r_bit <= '0;
            else            r_bit <= r_bit + BIT_ONE;
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        S_STOP: begin
          if (w_tick_last) r_tick <= '0;
          else             r_tick <= r_tick + TICK_ONE;
        end
        default: begin
          r_tick <= '0;
          r_bit  <= '0;
        end
      endcase
    end
  end

  // An ack on the same edge as a good stop bit still lets the new word in.
  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      if (i_rd_ack) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      if (w_stop_good) begin
        if (!r_rx_valid || i_rd_ack) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receive end of the team's serial shift-register link: recovers framed, LSB-first serial data from a single line and presents it as a parallel word.
- Frame format: idle-high line, 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
- Sits between the serial line pin and a parallel consumer. Uses a valid/ack hold register, overrun detection and framing-error detection.

Parameters:
- CLKS_PER_BIT, 4, clocks per serial bit; must be even and >= 2. HALF = CLKS_PER_BIT/2.
- DATA_BITS, 8, data bits per frame (1..16).

Ports:
- clk  input  1  clock; all state updates on the falling edge of clk.
- reset  input  1  asynchronous, active-high reset.
- rx_in  input  1  serial line, asynchronous to clk, idle high.
- rd_ack  input  1  consumer acknowledge; clears rx_valid.
- rx_data  output  DATA_BITS  last good received word.
- rx_valid  output  1  rx_data holds an unacknowledged word.
- overrun  output  1  sticky: a good frame was dropped because rx_valid was still high.
- frame_err  output  1  one-clock pulse: stop bit sampled 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0.
  - State=IDLE; sync flops=1; bit/tick counters=0; shift register=0.
  - Reset mid-frame abandons the frame; no output pulses.
- Synchronizer: rx_in passes through 2 falling-edge flops. All decisions use the second flop output, rxs.
- States: IDLE, START, DATA, STOP, BREAK. Counters: tick (0..CLKS_PER_BIT-1) and bit (0..DATA_BITS-1).
- IDLE: if rxs==0, go to START with tick=0; otherwise stay.
- START:
  - If tick==HALF-1: sample rxs and clear tick.
  - Sample 0 -> DATA with bit=0. Sample 1 (glitch) -> IDLE with no outputs.
  - Otherwise tick++.
- DATA:
  - If tick==CLKS_PER_BIT-1: shift rxs into the shift-register MSB (shift right), tick=0.
  - If bit==DATA_BITS-1, go to STOP; else bit++.
  - Otherwise tick++.
- STOP, on tick==CLKS_PER_BIT-1, sample rxs:
  - rxs==1, rx_valid==0 or rd_ack==1 this edge: rx_data<=shift register, rx_valid<=1; go to IDLE.
  - rxs==1, rx_valid==1 and rd_ack==0: word dropped, rx_data unchanged, overrun<=1; go to IDLE.
  - rxs==0: frame_err=1 for exactly one clock; word discarded; rx_data, rx_valid and overrun unchanged by the frame; go to BREAK.
- BREAK: wait until rxs==1, then IDLE. A line held low never retriggers a frame.
- rd_ack:
  - On any edge with rd_ack==1, rx_valid<=0 and overrun<=0, unless a good stop bit completes on the same edge. In that case rx_valid stays 1 with the new data and overrun is cleared.
  - rd_ack while rx_valid==0 has no effect.
- Latency: let E0 be the first falling edge that samples rx_in low at the start bit. rx_valid is first high after edge E0+2+HALF+DATA_BITS*CLKS_PER_BIT+CLKS_PER_BIT (with defaults, E0+40). Samples fall at bit midpoints.
- Back-to-back frames (next start bit immediately after stop bit) are received without loss. The STOP->IDLE transition leaves >= HALF-1 clocks of margin.
- rx_data changes only on a good frame accepted per the STOP rules.

Test Plan:
- Reset then send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with defaults -> rx_valid=1, rx_data=0xA5 exactly after edge E0+40; frame_err=0, overrun=0; rd_ack for one clock -> rx_valid=0.
- Back-to-back 0x3C then 0xC3, rd_ack pulsed after each -> two rx_valid assertions, data 0x3C then 0xC3; no error flags.
- Send 0x11, no ack, then send 0x22 -> rx_data stays 0x11, overrun=1 after the second stop bit; then rd_ack -> rx_valid=0, overrun=0.
- Frame 0x7E with stop bit forced 0, line then held low 20 clocks, then high -> frame_err one-clock pulse; rx_valid stays 0; no new frame starts until line high (busy stays 1 through BREAK).
- Start-bit glitch: rx_in low for 1 clock only -> START samples 1, return to IDLE; no outputs change.
- Assert reset during DATA bit 4 of a frame -> all outputs 0 immediately; a subsequent clean 0x5A frame is received correctly.
